// File: rtl/jtframe_romload_pkg.sv
// Shared types and constants for the ROM download stage.
package jtframe_romload_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_TAIL
    } state_t;

    // One queued SDRAM byte write: word address, byte and active-low lane mask.
    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } fifo_entry_t;

    localparam logic [1:0] MASK_EVEN  = 2'b10;
    localparam logic [1:0] MASK_ODD   = 2'b01;
    localparam int         FIFO_DEPTH = 4;

    // Lane mask for a byte; big-endian sets flip which lane an even byte lands in.
    function automatic logic [1:0] lane_mask(input logic odd, input logic swab);
        return (odd ^ swab) ? MASK_ODD : MASK_EVEN;
    endfunction

endpackage

// File: rtl/jtframe_romload_fifo.sv
// Four-entry synchronous FIFO that absorbs SDRAM write latency.
module jtframe_romload_fifo
    import jtframe_romload_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  fifo_entry_t din_i,
    input  logic        pop_i,
    output fifo_entry_t dout_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [2:0]  count_o
);

    fifo_entry_t mem_q [FIFO_DEPTH];
    logic [1:0]  wrPtr_q;
    logic [1:0]  rdPtr_q;
    logic [2:0]  count_q;
    logic        overrun_q;
    logic        doPush;
    logic        doPop;

    assign full_o  = (count_q == 3'(FIFO_DEPTH));
    assign empty_o = (count_q == 3'd0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rdPtr_q];

    // A push into a full FIFO is thrown away; a pop from an empty one does nothing.
    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    // Storage array, written only on accepted pushes and never reset.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

    // Pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q   <= 2'd0;
            rdPtr_q   <= 2'd0;
            count_q   <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 2'd1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            if (push_i && full_o) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // The upstream honours ioctl_wait, so an overrun means a broken handshake.
    overrunNever: assert property (@(posedge clk_i) disable iff (rst_i) !overrun_q);

endmodule

// File: rtl/jtframe_romload.sv
// ROM download stage: strips the header, splits PROM bytes off and feeds
// SDRAM byte writes through a small FIFO while tracking download activity.
module jtframe_romload
    import jtframe_romload_pkg::*;
#(
    parameter int          HEADER     = 0,
    parameter logic [21:0] PROM_START = 22'h3F_FFFF,
    parameter bit          SWAB       = 1'b0,
    parameter int          TAIL       = 16
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic        prog_rd,
    input  logic        prog_rdy,
    output logic        prom_we,
    output logic [21:0] prom_addr,
    output logic [7:0]  prom_data,
    output logic        dwnld_busy
);

    localparam logic [22:0] HEADER_W  = 23'(HEADER);
    localparam logic [15:0] TAIL_LOAD = 16'(TAIL - 1);

    logic [22:0] headerDiff;
    logic [21:0] offset;
    logic        inHeader;
    logic        isProm;
    logic        isSdram;
    fifo_entry_t pushEntry;
    fifo_entry_t fifoHead;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [2:0]  fifoCount;
    logic        pop;

    logic        prog_we_d;
    logic        prog_we_q;
    logic [21:0] prog_addr_q;
    logic [7:0]  prog_data_q;
    logic [1:0]  prog_mask_q;
    logic        prom_we_q;
    logic [21:0] prom_addr_q;
    logic [7:0]  prom_data_q;
    state_t      state_q;
    logic [15:0] tailCnt_q;
    logic        busy_q;

    // The borrow out of a 23-bit subtraction flags bytes still inside the header.
    assign headerDiff = {1'b0, ioctl_addr} - HEADER_W;
    assign inHeader   = headerDiff[22];
    assign offset     = headerDiff[21:0];
    assign isProm     = ioctl_wr && !inHeader && (offset >= PROM_START);
    assign isSdram    = ioctl_wr && !inHeader && (offset < PROM_START);

    assign pushEntry.addr = {1'b0, offset[21:1]};
    assign pushEntry.data = ioctl_data;
    assign pushEntry.mask = lane_mask(offset[0], SWAB);

    jtframe_romload_fifo u_fifo (
        .clk_i   (clk_sys),
        .rst_i   (rst),
        .push_i  (isSdram),
        .din_i   (pushEntry),
        .pop_i   (pop),
        .dout_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Load a new request only when the port is idle, which forces one idle cycle
    // between requests and keeps the prog_* outputs frozen while prog_we is high.
    assign pop = !prog_we_q && !fifoEmpty;

    // Request flag next state: raised by a pop, dropped by an acknowledge.
    always_comb begin
        prog_we_d = prog_we_q;
        if (pop) begin
            prog_we_d = 1'b1;
        end else if (prog_we_q && prog_rdy) begin
            prog_we_d = 1'b0;
        end
    end

    // SDRAM request registers.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            prog_we_q   <= 1'b0;
            prog_addr_q <= 22'd0;
            prog_data_q <= 8'd0;
            prog_mask_q <= 2'b00;
        end else begin
            prog_we_q <= prog_we_d;
            if (pop) begin
                prog_addr_q <= fifoHead.addr;
                prog_data_q <= fifoHead.data;
                prog_mask_q <= fifoHead.mask;
            end
        end
    end

    // PROM bytes bypass the FIFO and become a one-cycle registered strobe.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            prom_we_q   <= 1'b0;
            prom_addr_q <= 22'd0;
            prom_data_q <= 8'd0;
        end else begin
            prom_we_q <= isProm;
            if (isProm) begin
                prom_addr_q <= offset - PROM_START;
                prom_data_q <= ioctl_data;
            end
        end
    end

    // Download activity tracker; the tail starts on the edge that retires the last write.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tailCnt_q <= 16'd0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (downloading) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!downloading) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (downloading) begin
                        state_q <= ST_LOAD;
                    end else if ((fifoCount == 3'd0) && !prog_we_d) begin
                        state_q   <= ST_TAIL;
                        tailCnt_q <= TAIL_LOAD;
                    end
                end
                ST_TAIL: begin
                    if (downloading) begin
                        state_q <= ST_LOAD;
                    end else if (tailCnt_q == 16'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        tailCnt_q <= tailCnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ioctl_wait = fifoFull;
    assign prog_we    = prog_we_q;
    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign prog_rd    = 1'b0;
    assign prom_we    = prom_we_q;
    assign prom_addr  = prom_addr_q;
    assign prom_data  = prom_data_q;
    assign dwnld_busy = busy_q;

endmodule
